// File: rtl/rf_scrubber.sv
// Background scrubber for the ECC-protected register file: borrows read port 1 when the OP
// stage leaves it idle and repairs correctable errors through the write port when WB is quiet.
module rf_scrubber #(
    parameter int INTERVAL = 16,
    parameter int CNT_W    = 8
) (
    input  logic             s_clk_i,
    input  logic             s_resetn_i,
    input  logic             s_en_i,
    input  logic             s_op_rp1_use_i,
    input  logic [31:0]      s_rf_val_i,
    input  logic             s_rf_ce_i,
    input  logic             s_rf_uce_i,
    input  logic             s_wb_we_i,
    input  logic [4:0]       s_wb_add_i,
    output logic             s_scr_gnt_o,
    output logic [4:0]       s_scr_add_o,
    output logic             s_scr_we_o,
    output logic [31:0]      s_scr_wval_o,
    output logic             s_uce_o,
    output logic [CNT_W-1:0] s_ce_cnt_o,
    output logic             s_busy_o
);

    localparam int TMR_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [4:0]       addr;
    logic [31:0]      val_q;
    logic [CNT_W-1:0] ce_cnt;
    logic             uce_q;
    logic             gnt;
    logic             wb_hits_addr;

    // x0 is hardwired to zero, so the address walk skips it on wrap
    function automatic logic [4:0] next_addr(input logic [4:0] a);
        return (a == 5'd31) ? 5'd1 : a + 5'd1;
    endfunction

    assign gnt          = (state == REQ) && s_en_i && !s_op_rp1_use_i;
    assign wb_hits_addr = s_wb_we_i && (s_wb_add_i == addr);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state  <= IDLE;
            timer  <= '0;
            addr   <= 5'd1;
            val_q  <= '0;
            ce_cnt <= '0;
            uce_q  <= 1'b0;
        end else begin
            uce_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s_en_i) begin
                        timer <= '0;
                    end else if (timer == TMR_LAST) begin
                        timer <= '0;
                        state <= REQ;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REQ: begin
                    if (!s_en_i) begin
                        state <= IDLE;
                    end else if (gnt) begin
                        // A concurrent WB write to the same register supersedes whatever was read
                        if (wb_hits_addr) begin
                            addr  <= next_addr(addr);
                            state <= IDLE;
                        end else if (s_rf_uce_i) begin
                            uce_q <= 1'b1;
                            addr  <= next_addr(addr);
                            state <= IDLE;
                        end else if (s_rf_ce_i) begin
                            val_q <= s_rf_val_i;
                            state <= WRITE;
                        end else begin
                            addr  <= next_addr(addr);
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (!s_wb_we_i) begin
                        if (ce_cnt != CNT_MAX) begin
                            ce_cnt <= ce_cnt + 1'b1;
                        end
                        addr  <= next_addr(addr);
                        state <= IDLE;
                    end else if (s_wb_add_i == addr) begin
                        addr  <= next_addr(addr);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_scr_gnt_o  = gnt;
    assign s_scr_add_o  = addr;
    assign s_scr_we_o   = (state == WRITE) && !s_wb_we_i;
    assign s_scr_wval_o = (state == WRITE) ? val_q : 32'd0;
    assign s_uce_o      = uce_q;
    assign s_ce_cnt_o   = ce_cnt;
    assign s_busy_o     = (state != IDLE);

endmodule

// File: tb/tb_rf_scrubber.sv
// Scoreboard bench for rf_scrubber: expected grants, writes and uce pulses are queued as each
// scrub is launched and matched by a negedge monitor when the DUT produces them.
module tb_rf_scrubber;

    localparam int INTERVAL = 16;
    localparam int CNT_W    = 8;
    localparam int K_GNT    = 1;
    localparam int K_WR     = 2;
    localparam int K_UCE    = 3;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             rp1_use;
    logic [31:0]      rf_val;
    logic             rf_ce;
    logic             rf_uce;
    logic             wb_we;
    logic [4:0]       wb_add;
    logic             gnt;
    logic [4:0]       scr_add;
    logic             scr_we;
    logic [31:0]      scr_wval;
    logic             uce;
    logic [CNT_W-1:0] ce_cnt;
    logic             busy;

    exp_t       sb[$];
    int         num_checks = 0;
    int         num_fail   = 0;
    logic [4:0] exp_addr;
    int         exp_cnt;
    int         cyc = 0;
    int         last_gnt_cyc = 0;
    bit         have_last = 1'b0;
    bit         period_on = 1'b0;

    rf_scrubber #(.INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
        .s_clk_i        (clk),
        .s_resetn_i     (rst_n),
        .s_en_i         (en),
        .s_op_rp1_use_i (rp1_use),
        .s_rf_val_i     (rf_val),
        .s_rf_ce_i      (rf_ce),
        .s_rf_uce_i     (rf_uce),
        .s_wb_we_i      (wb_we),
        .s_wb_add_i     (wb_add),
        .s_scr_gnt_o    (gnt),
        .s_scr_add_o    (scr_add),
        .s_scr_we_o     (scr_we),
        .s_scr_wval_o   (scr_wval),
        .s_uce_o        (uce),
        .s_ce_cnt_o     (ce_cnt),
        .s_busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] nextAddr(input logic [4:0] a);
        return (a == 5'd31) ? 5'd1 : a + 5'd1;
    endfunction

    task automatic push(input int kind, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // sel 0: grant high, 1: scrubber idle, 2: scrubber busy
    task automatic waitFor(input int sel, input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 0 && gnt) || (sel == 1 && !busy) || (sel == 2 && busy)) return;
        end
        if (sel == 0) checkOutput(tag, 32'(gnt), 32'd1);
        else if (sel == 1) checkOutput(tag, 32'(busy), 32'd0);
        else checkOutput(tag, 32'(busy), 32'd1);
    endtask

    task automatic checkModel();
        checkOutput("ce_cnt", 32'(ce_cnt), 32'(exp_cnt));
        checkOutput("scr_add", 32'(scr_add), 32'(exp_addr));
    endtask

    // One complete scrub with WB quiet and read port 1 free
    task automatic applyStimulus(input logic ce, input logic ue, input logic [31:0] v);
        sync();
        rf_ce  = ce;
        rf_uce = ue;
        rf_val = v;
        push(K_GNT, exp_addr, 32'd0);
        if (ue) push(K_UCE, nextAddr(exp_addr), 32'd0);
        else if (ce) push(K_WR, exp_addr, v);
        waitFor(0, "gnt_timeout");
        waitFor(1, "idle_timeout");
        if (ce && !ue && exp_cnt < 255) exp_cnt++;
        exp_addr = nextAddr(exp_addr);
        checkModel();
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   kind;
        cyc++;
        if (rst_n && (gnt || scr_we || uce)) begin
            kind = gnt ? K_GNT : (scr_we ? K_WR : K_UCE);
            if (gnt || scr_we) checkOutput("gnt_we_excl", 32'(gnt & scr_we), 32'd0);
            if (gnt) begin
                if (period_on && have_last)
                    checkOutput("gnt_period", 32'(cyc - last_gnt_cyc), 32'(INTERVAL + 1));
                have_last    = 1'b1;
                last_gnt_cyc = cyc;
            end
            if (sb.size() == 0) begin
                checkOutput("unexpected_event", 32'(kind), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("event_kind", 32'(kind), 32'(e.kind));
                checkOutput("event_addr", 32'(scr_add), 32'(e.addr));
                if (kind == K_WR) checkOutput("event_wval", scr_wval, e.val);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        rp1_use = 1'b0;
        rf_val  = 32'd0;
        rf_ce   = 1'b0;
        rf_uce  = 1'b0;
        wb_we   = 1'b0;
        wb_add  = 5'd0;
        exp_addr = 5'd1;
        exp_cnt  = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_add", 32'(scr_add), 32'd1);
        checkOutput("rst_we", 32'(scr_we), 32'd0);
        checkOutput("rst_wval", scr_wval, 32'd0);
        checkOutput("rst_uce", 32'(uce), 32'd0);
        checkOutput("rst_cnt", 32'(ce_cnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        sync();
        rst_n = 1'b1;

        $display("[TB] clean sweep over all addresses");
        period_on = 1'b1;
        for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        period_on = 1'b0;

        $display("[TB] correctable error at address 5");
        while (exp_addr != 5'd5) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);

        $display("[TB] OP stage holds read port 1 during REQ");
        sync();
        rf_ce   = 1'b0;
        rf_uce  = 1'b0;
        rp1_use = 1'b1;
        push(K_GNT, exp_addr, 32'd0);
        waitFor(2, "busy_timeout");
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("rp1_hold_gnt", 32'(gnt), 32'd0);
            checkOutput("rp1_hold_busy", 32'(busy), 32'd1);
        end
        sync();
        rp1_use = 1'b0;
        #1;
        checkOutput("rp1_release_gnt", 32'(gnt), 32'd1);
        waitFor(1, "idle_timeout");
        exp_addr = nextAddr(exp_addr);
        checkModel();

        $display("[TB] write deferred by WB to another register");
        sync();
        rf_ce  = 1'b1;
        rf_val = 32'h12345678;
        wb_we  = 1'b1;
        wb_add = 5'd3;
        push(K_GNT, exp_addr, 32'd0);
        push(K_WR, exp_addr, 32'h12345678);
        waitFor(0, "gnt_timeout");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("deferred_we", 32'(scr_we), 32'd0);
            checkOutput("deferred_wval", scr_wval, 32'h12345678);
        end
        sync();
        wb_we = 1'b0;
        waitFor(1, "idle_timeout");
        exp_cnt++;
        exp_addr = nextAddr(exp_addr);
        checkModel();

        $display("[TB] write cancelled by WB to the same register");
        sync();
        rf_ce  = 1'b1;
        rf_val = 32'hA5A5A5A5;
        push(K_GNT, exp_addr, 32'd0);
        waitFor(0, "gnt_timeout");
        wb_we  = 1'b1;
        wb_add = exp_addr;
        waitFor(1, "idle_timeout");
        sync();
        wb_we = 1'b0;
        exp_addr = nextAddr(exp_addr);
        checkModel();

        $display("[TB] uncorrectable error at address 9");
        checkOutput("uce_addr_setup", 32'(scr_add), 32'd9);
        applyStimulus(1'b1, 1'b1, 32'h0BADF00D);
        @(negedge clk);
        checkOutput("uce_pulse_width", 32'(uce), 32'd0);

        $display("[TB] corrected-error counter saturation");
        for (int i = 0; i < 258; i++) applyStimulus(1'b1, 1'b0, $urandom);
        checkOutput("cnt_saturated", 32'(ce_cnt), 32'd255);

        $display("[TB] reset during WRITE");
        sync();
        rf_ce  = 1'b1;
        rf_val = 32'hCAFEF00D;
        push(K_GNT, exp_addr, 32'd0);
        push(K_WR, exp_addr, 32'hCAFEF00D);
        waitFor(0, "gnt_timeout");
        @(negedge clk);
        checkOutput("we_before_reset", 32'(scr_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_we", 32'(scr_we), 32'd0);
        checkOutput("rstw_wval", scr_wval, 32'd0);
        checkOutput("rstw_busy", 32'(busy), 32'd0);
        checkOutput("rstw_add", 32'(scr_add), 32'd1);
        checkOutput("rstw_cnt", 32'(ce_cnt), 32'd0);
        sync();
        rf_ce = 1'b0;
        rst_n = 1'b1;
        exp_addr = 5'd1;
        exp_cnt  = 0;
        applyStimulus(1'b0, 1'b0, 32'd0);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
